// File: rtl/ov7642_y_capture.sv
// Camera Y-byte capture: strips dummy bytes from a Y/dummy interleaved href stream and writes a
// WIDTH x HEIGHT luminance frame into a frame-buffer write port, flagging malformed geometry.
module ov7642_y_capture #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              pclk_i,
  input  logic              n_rst_i,
  input  logic              capture_en_i,
  input  logic              err_clr_i,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic [7:0]        data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              frame_done_o,
  output logic [CNT_W-1:0]  frame_count_o,
  output logic              busy_o,
  output logic              line_err_o,
  output logic              frame_err_o
);

  localparam int unsigned ColW = $clog2(WIDTH + 2);
  localparam int unsigned RowW = $clog2(HEIGHT + 2);

  localparam logic [ColW-1:0] ColEnd = ColW'(WIDTH);
  localparam logic [ColW-1:0] ColSat = ColW'(WIDTH + 1);
  localparam logic [RowW-1:0] RowEnd = RowW'(HEIGHT);
  localparam logic [RowW-1:0] RowSat = RowW'(HEIGHT + 1);

  typedef enum logic [1:0] {StIdle, StSync, StActive} state_e;

  state_e state_q, state_d;

  logic              vs_q, vs_q2, hr_q, hr_q2;
  logic [7:0]        d_q;
  logic              phase_q, phase_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  frame_count_q, frame_count_d;
  logic              line_err_q, line_err_d;
  logic              frame_err_q, frame_err_d;
  logic              line_set, frame_set;

  logic vs_rise, hr_fall;
  assign vs_rise = vs_q & ~vs_q2;
  assign hr_fall = ~hr_q & hr_q2;

  always_comb begin
    state_d       = state_q;
    phase_d       = hr_q ? ~phase_q : 1'b0;
    col_d         = col_q;
    row_d         = row_q;
    base_d        = base_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    line_set      = 1'b0;
    frame_set     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (capture_en_i && vs_q) state_d = StSync;
      end
      StSync: begin
        if (!vs_q) begin
          state_d = StActive;
          row_d   = '0;
          col_d   = '0;
          base_d  = '0;
        end
      end
      StActive: begin
        if (vs_rise) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + CNT_W'(1);
          frame_set     = (row_q != RowEnd);
          state_d       = capture_en_i ? StSync : StIdle;
        end else if (hr_q && !phase_q) begin
          if (col_q < ColEnd && row_q < RowEnd) begin
            wr_en_d   = 1'b1;
            wr_data_d = d_q;
            wr_addr_d = base_q + ADDR_W'(col_q);
          end
          if (col_q != ColSat) col_d = col_q + ColW'(1);
        end else if (hr_fall) begin
          line_set = (col_q != ColEnd);
          if (row_q != RowSat) row_d = row_q + RowW'(1);
          // base only matters for in-frame rows, so stop advancing it past the last one
          if (row_q < RowEnd) base_d = base_q + ADDR_W'(WIDTH);
          col_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A set in the same cycle as err_clr wins
    line_err_d  = (line_err_q & ~err_clr_i) | line_set;
    frame_err_d = (frame_err_q & ~err_clr_i) | frame_set;
  end

  always_ff @(posedge pclk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q       <= StIdle;
      vs_q          <= 1'b0;
      vs_q2         <= 1'b0;
      hr_q          <= 1'b0;
      hr_q2         <= 1'b0;
      d_q           <= '0;
      phase_q       <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      base_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vsync_i;
      vs_q2         <= vs_q;
      hr_q          <= href_i;
      hr_q2         <= hr_q;
      d_q           <= data_i;
      phase_q       <= phase_d;
      col_q         <= col_d;
      row_q         <= row_d;
      base_q        <= base_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign frame_done_o  = frame_done_q;
  assign frame_count_o = frame_count_q;
  assign busy_o        = (state_q != StIdle);
  assign line_err_o    = line_err_q;
  assign frame_err_o   = frame_err_q;

endmodule
